// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for a simple processor bus.
// A request is accepted in IDLE, optionally held in WAIT for WAIT_CYCLES
// cycles, then answered with a one-cycle ready pulse in RESP.
// Address map: word RAM at 0..DEPTH_WORDS*4-1, led register at MMIO_BASE,
// free-running cycle counter (read-only) at MMIO_BASE+4.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req/we/addr/wd/be request strobe, write flag, byte address, write data, byte enables
//   rd/ready/err      response data, response strobe, error flag (0 unless ready)
//   led               MMIO output register
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic [31:0] led
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WLOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] cyc;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic [31:0] cyc_cnt;
  req_t        req_q, cur;
  logic [31:0] mem [DEPTH_WORDS];

  logic        go_resp;
  logic        aligned, hit_ram, hit_led, hit_cyc, dec_err;
  logic [AW-1:0] idx;
  logic [31:0] bmask, rd_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wcnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live inputs must be used instead of the captured copy.
  always_comb begin
    cur = req_q;
    if (state == IDLE) cur = {we, addr, wd, be, cyc_cnt};
  end

  assign go_resp = (state_nxt == RESP);

  // Address decode
  assign aligned = (cur.addr[1:0] == 2'b00);
  assign hit_ram = aligned && (cur.addr[31:AW+2] == '0);
  assign hit_led = (cur.addr == MMIO_BASE);
  assign hit_cyc = (cur.addr == MMIO_BASE + 32'd4);
  assign dec_err = !(hit_ram || hit_led || hit_cyc);
  assign idx     = cur.addr[AW+1:2];
  assign bmask   = {{8{cur.be[3]}}, {8{cur.be[2]}}, {8{cur.be[1]}}, {8{cur.be[0]}}};

  always_comb begin
    rd_nxt = 32'd0;
    if (!cur.we && !dec_err) begin
      if (hit_ram)      rd_nxt = mem[idx];
      else if (hit_led) rd_nxt = led;
      else              rd_nxt = cur.cyc;
    end
  end

  assign ready = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      cyc_cnt <= 32'd0;
      req_q   <= '0;
      led     <= 32'd0;
      rd      <= 32'd0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state == IDLE && req) begin
        req_q <= cur;
        wcnt  <= WLOAD;
      end else if (state == WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      // Response payload is only non-zero while in RESP.
      rd  <= go_resp ? rd_nxt  : 32'd0;
      err <= go_resp ? dec_err : 1'b0;
      if (go_resp && cur.we && hit_led)
        led <= (led & ~bmask) | (cur.wd & bmask);
    end
  end

  // RAM has no reset; the reset term keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (reset && go_resp && cur.we && hit_ram) begin
      for (int i = 0; i < 4; i++)
        if (cur.be[i]) mem[idx][8*i +: 8] <= cur.wd[8*i +: 8];
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, the number of 32-bit RAM words (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, the wait states inserted before each response (0..15).
REQ-003 The block SHALL have parameter MMIO_BASE, default 32'h0000_0400, the byte address of the MMIO output register; MMIO_BASE+4 is the cycle counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req  input  1  request strobe from the processor side.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  32  byte address; sampled with req.
REQ-009 wd  input  32  write data; sampled with req.
REQ-010 be  input  4  byte enables for writes, be[i] selects wd[8i+7:8i]; sampled with req.
REQ-011 rd  output  32  read data, valid only while ready=1.
REQ-012 ready  output  1  one-cycle response strobe.
REQ-013 err  output  1  error flag, valid only while ready=1.
REQ-014 led  output  32  MMIO output register contents.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; only IDLE accepts requests.
REQ-016 Acceptance: a rising edge in IDLE with req=1 SHALL register we, addr, wd, be, and the cycle counter value.
REQ-017 After acceptance, the FSM SHALL go to RESP if WAIT_CYCLES=0, else to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-018 WAIT SHALL decrement each cycle and go to RESP on the edge after the counter reads 0; total WAIT dwell SHALL be exactly WAIT_CYCLES cycles.
REQ-019 ready SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL always return to IDLE.
REQ-020 Latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to ready=1; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-021 req SHALL be ignored in WAIT and RESP; req held high through RESP SHALL be accepted again at the edge leaving RESP... only if the FSM is in IDLE at that edge, i.e. not before the following cycle.
REQ-022 Decode: addr[1:0]!=0 SHALL be misaligned -> err=1, rd=0, no state change.
REQ-023 Aligned addr < DEPTH_WORDS*4 SHALL select RAM word addr[log2(DEPTH_WORDS)+1:2].
REQ-024 addr==MMIO_BASE SHALL select led (read/write); addr==MMIO_BASE+4 SHALL select the cycle counter (read-only, writes silently ignored, err=0).
REQ-025 Any other aligned address SHALL give err=1, rd=0, no write.
REQ-026 Writes SHALL update only bytes with be[i]=1, committed on the edge entering RESP; be=4'b0000 SHALL be a no-op with err=0.
REQ-027 For writes, rd SHALL be 0 in RESP.
REQ-028 Reads SHALL return the target contents as of the edge entering RESP, so a read after a completed write returns the new data.
REQ-029 The cycle counter SHALL be 32 bits, increment every cycle out of reset, and wrap 32'hFFFF_FFFF -> 0; a read SHALL return the value registered at acceptance.
REQ-030 rd and err SHALL be 0 whenever ready=0.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, ready=0, err=0, rd=0, led=0, cycle counter=0, wait counter=0.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 reset asserted mid-transaction SHALL abort it; a write whose commit edge has not occurred SHALL NOT be committed.
REQ-034 Requests SHALL be accepted from the first rising edge after reset returns to 1.

Verification
REQ-035 WAIT_CYCLES=1: write addr=0x10, wd=0xDEADBEEF, be=4'hF, then read 0x10 -> ready 2 cycles after each acceptance, rd=0xDEADBEEF, err=0.
REQ-036 Byte enables: RAM[0x10]=0xDEADBEEF, write wd=0x11223344 be=4'b0101 -> read 0x10 gives 0xDE22BE44.
REQ-037 Errors: read addr=0x12 -> err=1, rd=0; write 0x0000_0800 -> err=1, contents unchanged; write MMIO_BASE+4 -> err=0, counter unaffected.
REQ-038 MMIO: write MMIO_BASE wd=0x000000A5 -> led=0x000000A5 after the commit edge; read MMIO_BASE+4 at acceptance cycle k after reset -> rd=k.
REQ-039 Reset during WAIT of a write to 0x20 (old 0x0) -> ready stays 0, led=0; subsequent read of 0x20 returns 0x0.
REQ-040 WAIT_CYCLES=0 with req held high -> ready pulses every 2nd cycle, one response per pulse, no response dropped or duplicated.
